// File: rtl/miriscv_rvfi_checker.sv
// -----------------------------------------------------------------------------
// miriscv_rvfi_checker
// Sits on the core's registered RVFI retirement port. Each valid retirement is
// checked for order sequence, PC continuity, x0 write value and memory mask
// legality. A compact trace record tagged with the error bits is queued in a
// small FIFO that drains over a valid/ready stream. Sticky error flags, a
// saturating drop counter and a wrapping retirement counter are also kept.
//
// Ports
//   clk_i, areset_i            : clock (rising edge), async active-high reset
//   rvfi_*_i                   : retirement fields from the core
//   trace_valid_o/ready_i      : trace stream handshake
//   trace_pc_o .. trace_err_o  : head FIFO record (pc, insn, rd, wdata, err)
//   sticky_clr_i               : clears err_sticky_o and drop_cnt_o
//   err_sticky_o               : OR of error bits since reset/clear
//   drop_cnt_o                 : retirements lost to a full FIFO (saturates)
//   retired_cnt_o              : valid retirements seen (wraps)
// -----------------------------------------------------------------------------
module miriscv_rvfi_checker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             areset_i,
   input  logic             rvfi_valid_i,
   input  logic [63:0]      rvfi_order_i,
   input  logic [31:0]      rvfi_insn_i,
   input  logic             rvfi_intr_i,
   input  logic [4:0]       rvfi_rd_addr_i,
   input  logic [31:0]      rvfi_rd_wdata_i,
   input  logic [31:0]      rvfi_pc_rdata_i,
   input  logic [31:0]      rvfi_pc_wdata_i,
   input  logic [31:0]      rvfi_mem_addr_i,
   input  logic [3:0]       rvfi_mem_rmask_i,
   input  logic [3:0]       rvfi_mem_wmask_i,
   output logic             trace_valid_o,
   input  logic             trace_ready_i,
   output logic [31:0]      trace_pc_o,
   output logic [31:0]      trace_insn_o,
   output logic [4:0]       trace_rd_addr_o,
   output logic [31:0]      trace_rd_wdata_o,
   output logic [3:0]       trace_err_o,
   input  logic             sticky_clr_i,
   output logic [3:0]       err_sticky_o,
   output logic [CNT_W-1:0] drop_cnt_o,
   output logic [31:0]      retired_cnt_o
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int REC_W = 32 + 32 + 5 + 32 + 4;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Memory access legality: single access kind, byte/half/word mask, natural alignment.
   function automatic logic mem_illegal(input logic [3:0] rmask,
                                        input logic [3:0] wmask,
                                        input logic [1:0] addr_lo);
      logic [3:0] mask;
      logic       bad;
      mask = rmask | wmask;
      bad  = (rmask != 4'b0000) && (wmask != 4'b0000);
      case (mask)
         4'b0000: bad = bad;
         4'b0001: bad = bad;
         4'b0011: bad = bad | addr_lo[0];
         4'b1111: bad = bad | (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   logic [63:0]      exp_order_r;
   logic             first_r;
   logic [31:0]      prev_pc_r;
   logic [REC_W-1:0] fifo_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;

   logic [3:0]       err_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic             full_s;
   logic [CNT_W-1:0] drop_nxt_s;
   logic [3:0]       sticky_nxt_s;

   // Invariant checks on the retirement presented this cycle.
   always_comb begin
      err_s = 4'b0000;
      if (rvfi_valid_i) begin
         err_s[0] = (rvfi_order_i != exp_order_r);
         err_s[1] = !first_r && !rvfi_intr_i && (rvfi_pc_rdata_i != prev_pc_r);
         err_s[2] = (rvfi_rd_addr_i == 5'd0) && (rvfi_rd_wdata_i != 32'd0);
         err_s[3] = mem_illegal(rvfi_mem_rmask_i, rvfi_mem_wmask_i, rvfi_mem_addr_i[1:0]);
      end else begin
         err_s = 4'b0000;
      end
   end

   assign trace_valid_o = (count_r != {(AW+1){1'b0}});
   assign full_s        = (count_r == FULL_CNT);
   assign pop_s         = trace_valid_o & trace_ready_i;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push_s        = rvfi_valid_i & (~full_s | pop_s);
   assign drop_s        = rvfi_valid_i & ~push_s;

   assign {trace_pc_o, trace_insn_o, trace_rd_addr_o, trace_rd_wdata_o, trace_err_o} = fifo_r[rd_ptr_r];

   // Next sticky/drop values; a clear coinciding with a new event keeps the new event.
   always_comb begin
      sticky_nxt_s = err_sticky_o;
      drop_nxt_s   = drop_cnt_o;
      if (sticky_clr_i) begin
         sticky_nxt_s = err_s;
         drop_nxt_s   = drop_s ? CNT_W'(1) : {CNT_W{1'b0}};
      end else begin
         sticky_nxt_s = err_sticky_o | err_s;
         if (drop_s && (drop_cnt_o != {CNT_W{1'b1}})) begin
            drop_nxt_s = drop_cnt_o + CNT_W'(1);
         end else begin
            drop_nxt_s = drop_cnt_o;
         end
      end
   end

   // Reference state for the order and PC continuity checks.
   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         exp_order_r <= 64'd0;
         first_r     <= 1'b1;
         prev_pc_r   <= 32'd0;
      end else if (rvfi_valid_i) begin
         exp_order_r <= rvfi_order_i + 64'd1;
         first_r     <= 1'b0;
         prev_pc_r   <= rvfi_pc_wdata_i;
      end
   end

   // Trace FIFO storage, pointers and occupancy.
   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_r[i] <= {REC_W{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= {rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, err_s};
            wr_ptr_r         <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Status registers: sticky errors, drop counter, retirement counter.
   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         err_sticky_o  <= 4'b0000;
         drop_cnt_o    <= {CNT_W{1'b0}};
         retired_cnt_o <= 32'd0;
      end else begin
         err_sticky_o <= sticky_nxt_s;
         drop_cnt_o   <= drop_nxt_s;
         if (rvfi_valid_i) begin
            retired_cnt_o <= retired_cnt_o + 32'd1;
         end
      end
   end

endmodule
